bch_dec_top: RTL and testbench



---
 rtl/bch_dec_top.sv | 164 ++++++++++++++++
 tb/tb_bch_dec_top.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bch_dec_top.sv
// Registered decoder for a double-error-correcting BCH(75,63) code over GF(64).
// Everything between IN and the output registers is combinational:
// syndrome evaluation, classification, a parallel root search over all
// 63 nonzero field elements, and the data-bit correction.
module bch_dec_top (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [74:0] IN,
  output logic [62:0] OUT,
  output logic [11:0] SYN,
  output logic        ERR,
  output logic        SGL,
  output logic        DBL
);

  // alpha^e in the polynomial basis of x^6+x+1 (alpha^6 = alpha + 1).
  // Only ever called with elaboration-time constants.
  function automatic logic [5:0] alpha_pow(input int e);
    logic [5:0] v;
    v = 6'd1;
    for (int n = 0; n < (e % 63); n++) begin
      v = {v[4:0], 1'b0} ^ (v[5] ? 6'b000011 : 6'b000000);
    end
    return v;
  endfunction

  // GF(64) multiply, shift-and-add with reduction by x^6+x+1.
  function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
    logic [5:0] p;
    logic [5:0] t;
    p = 6'd0;
    t = a;
    for (int n = 0; n < 6; n++) begin
      if (b[n]) p = p ^ t;
      t = {t[4:0], 1'b0} ^ (t[5] ? 6'b000011 : 6'b000000);
    end
    return p;
  endfunction

  genvar gi;

  logic [5:0]  s1_term [75];
  logic [5:0]  s3_term [75];
  logic [5:0]  s1;
  logic [5:0]  s3;
  logic [5:0]  s1_sq;
  logic [5:0]  s1_cube;
  logic [5:0]  cterm;
  logic [62:0] sgl_hit;
  logic [62:0] dbl_hit;
  logic [6:0]  root_cnt;
  logic [62:0] loc_mask;
  logic [62:0] flip;
  logic        is_sgl;
  logic        is_dbl;

  logic [62:0] out_d, out_q;
  logic [11:0] syn_d, syn_q;
  logic        err_d, err_q;
  logic        sgl_d, sgl_q;
  logic        dbl_d, dbl_q;

  // Each received bit contributes a constant alpha power to S1 and S3.
  // Data bit k sits at x^(k+12); parity bit j sits at x^j.
  generate
    for (gi = 0; gi < 75; gi++) begin : g_syn_term
      localparam int         LOC = (gi < 63) ? gi + 12 : gi - 63;
      localparam logic [5:0] A1  = alpha_pow(LOC);
      localparam logic [5:0] A3  = alpha_pow(3 * LOC);
      assign s1_term[gi] = IN[gi] ? A1 : 6'd0;
      assign s3_term[gi] = IN[gi] ? A3 : 6'd0;
    end
  endgenerate

  // Accumulate the syndromes S1 = r(alpha), S3 = r(alpha^3).
  always_comb begin
    s1 = 6'd0;
    s3 = 6'd0;
    for (int i = 0; i < 75; i++) begin
      s1 = s1 ^ s1_term[i];
      s3 = s3 ^ s3_term[i];
    end
  end

  assign s1_sq   = gf_mul(s1, s1);
  assign s1_cube = gf_mul(s1_sq, s1);
  // Zero exactly when S3 = S1^3, i.e. the single-error signature.
  assign cterm   = s3 ^ s1_cube;

  // Parallel search over beta = alpha^i.
  // sgl_hit: beta equals S1, which gives log(S1) without a log table.
  // dbl_hit: beta is a root of S1*x^2 + S1^2*x + (S3 + S1^3), the locator
  // x^2 + S1*x + (S3/S1 + S1^2) scaled by S1 so that no division is needed.
  generate
    for (gi = 0; gi < 63; gi++) begin : g_root
      localparam logic [5:0] B1 = alpha_pow(gi);
      localparam logic [5:0] B2 = alpha_pow(2 * gi);
      assign sgl_hit[gi] = (s1 == B1);
      assign dbl_hit[gi] = ((gf_mul(s1, B2) ^ gf_mul(s1_sq, B1) ^ cterm) == 6'd0);
    end
  endgenerate

  // Count locator roots; a correctable double error has exactly two.
  always_comb begin
    root_cnt = 7'd0;
    for (int i = 0; i < 63; i++) begin
      root_cnt = root_cnt + {6'd0, dbl_hit[i]};
    end
  end

  // Classify the word and pick the set of error locations to correct.
  always_comb begin
    is_sgl   = (s1 != 6'd0) && (cterm == 6'd0);
    is_dbl   = (s1 != 6'd0) && (cterm != 6'd0) && (root_cnt == 7'd2);
    loc_mask = 63'd0;
    if (is_sgl) begin
      loc_mask = sgl_hit;
    end else if (is_dbl) begin
      loc_mask = dbl_hit;
    end
  end

  // Location L corrects data bit (L-12) mod 63; locations 0..11 alias
  // onto data bits 51..62, so the correction always lands in the data.
  generate
    for (gi = 0; gi < 63; gi++) begin : g_flip
      localparam int SRC = (gi + 12) % 63;
      assign flip[gi] = loc_mask[SRC];
    end
  endgenerate

  // Next-state values for the output registers.
  always_comb begin
    out_d = IN[62:0] ^ flip;
    syn_d = {s3, s1};
    err_d = (s1 != 6'd0) || (s3 != 6'd0);
    sgl_d = is_sgl;
    dbl_d = is_dbl;
  end

  // Output registers, cleared asynchronously while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= 63'd0;
      syn_q <= 12'd0;
      err_q <= 1'b0;
      sgl_q <= 1'b0;
      dbl_q <= 1'b0;
    end else begin
      out_q <= out_d;
      syn_q <= syn_d;
      err_q <= err_d;
      sgl_q <= sgl_d;
      dbl_q <= dbl_d;
    end
  end

  assign OUT = out_q;
  assign SYN = syn_q;
  assign ERR = err_q;
  assign SGL = sgl_q;
  assign DBL = dbl_q;

endmodule

// File: tb/tb_bch_dec_top.sv
// Bench for bch_dec_top: a new word every cycle, expected results queued at
// drive time and checked one clock later on the falling edge.
module tb_bch_dec_top;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [74:0] IN;
  logic [62:0] OUT;
  logic [11:0] SYN;
  logic        ERR;
  logic        SGL;
  logic        DBL;

  bch_dec_top dut (
    .clk  (clk),
    .rst_n(rst_n),
    .IN   (IN),
    .OUT  (OUT),
    .SYN  (SYN),
    .ERR  (ERR),
    .SGL  (SGL),
    .DBL  (DBL)
  );

  always #5 clk = ~clk;

  // mode 0: check OUT, SYN and flags; mode 1: OUT and flags;
  // mode 2: uncorrectable word, only ERR=1 and SGL/DBL exclusive.
  typedef struct {
    logic [62:0] out;
    logic [11:0] syn;
    logic        err;
    logic        sgl;
    logic        dbl;
    int          mode;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   next_id = 0;

  // Reference parity: (d(x) * x^12) mod g(x), by serial long division.
  function automatic logic [11:0] calc_parity(input logic [62:0] d);
    logic [11:0] r;
    logic        fb;
    r = 12'd0;
    for (int k = 62; k >= 0; k--) begin
      fb = d[k] ^ r[11];
      r  = {r[10:0], 1'b0};
      if (fb) r = r ^ 12'h539;
    end
    return r;
  endfunction

  function automatic exp_t mk(input logic [62:0] o, input logic [11:0] s, input logic e,
                              input logic sg, input logic db, input int m);
    exp_t x;
    x.out  = o;
    x.syn  = s;
    x.err  = e;
    x.sgl  = sg;
    x.dbl  = db;
    x.mode = m;
    x.id   = next_id;
    next_id++;
    return x;
  endfunction

  task automatic cmp(input string tag, input int id, input logic [62:0] act, input logic [62:0] exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s id=%0d observed=%h expected=%h", tag, id, act, exp);
    end
    $display("[TB] check %s id=%0d observed=%h expected=%h", tag, id, act, exp);
  endtask

  task automatic check_zero(input int id);
    cmp("rst_out", id, OUT, 63'd0);
    cmp("rst_syn", id, {51'd0, SYN}, 63'd0);
    cmp("rst_err", id, {62'd0, ERR}, 63'd0);
    cmp("rst_sgl", id, {62'd0, SGL}, 63'd0);
    cmp("rst_dbl", id, {62'd0, DBL}, 63'd0);
  endtask

  task automatic check_front();
    exp_t e;
    e = exp_q.pop_front();
    if (e.mode != 2) begin
      cmp("out", e.id, OUT, e.out);
      cmp("err", e.id, {62'd0, ERR}, {62'd0, e.err});
      cmp("sgl", e.id, {62'd0, SGL}, {62'd0, e.sgl});
      cmp("dbl", e.id, {62'd0, DBL}, {62'd0, e.dbl});
    end
    if (e.mode == 0) begin
      cmp("syn", e.id, {51'd0, SYN}, {51'd0, e.syn});
    end
    if (e.mode == 2) begin
      cmp("err_uncorr", e.id, {62'd0, ERR}, 63'd1);
      cmp("sgl_dbl_excl", e.id, {62'd0, (SGL & DBL)}, 63'd0);
    end
  endtask

  // One pipeline slot: check the result of the previous word, drive the next.
  task automatic drive(input logic [74:0] w, input exp_t e);
    @(negedge clk);
    if (exp_q.size() > 0) check_front();
    IN = w;
    exp_q.push_back(e);
  endtask

  initial begin
    logic [11:0] par_tab [9];
    logic [62:0] data;
    logic [11:0] par;
    int          a;
    int          b;
    int          j;

    par_tab = '{12'h539, 12'hA72, 12'hF4B, 12'h1DD, 12'h4E4, 12'hBAF, 12'hE96, 12'h3BA, 12'h683};

    // Reset held with all-ones input: outputs stay zero across clock edges.
    rst_n = 1'b0;
    IN    = '1;
    repeat (3) @(negedge clk);
    check_zero(-1);
    rst_n = 1'b1;
    IN    = 75'd0;
    exp_q.push_back(mk(63'd0, 12'd0, 1'b0, 1'b0, 1'b0, 0));

    // Clean codewords for data 1..9.
    for (int i = 0; i < 9; i++) begin
      data = 63'(i + 1);
      drive({par_tab[i], data}, mk(data, 12'd0, 1'b0, 1'b0, 1'b0, 0));
    end

    // Single error at IN[1], double at IN[1..2], triple at IN[1..3].
    drive({12'h539, 63'b11}, mk(63'd1, {6'b110110, 6'b001010}, 1'b1, 1'b1, 1'b0, 0));
    drive({12'h539, 63'b111}, mk(63'd1, 12'd0, 1'b1, 1'b0, 1'b1, 1));
    drive({12'h539, 63'b1111}, mk(63'd0, 12'd0, 1'b1, 1'b0, 1'b0, 2));

    // Highest data bit flipped (location 11) and parity-bit errors that
    // alias onto data bits 51..62.
    data = 63'h1234_5678_9ABC_DEF0;
    par  = calc_parity(data);
    drive({par, data ^ (63'd1 << 62)}, mk(data, 12'd0, 1'b1, 1'b1, 1'b0, 1));
    drive({par ^ 12'h001, data}, mk(data ^ (63'd1 << 51), 12'd0, 1'b1, 1'b1, 1'b0, 1));
    drive({par ^ 12'h800, data}, mk(data ^ (63'd1 << 62), 12'd0, 1'b1, 1'b1, 1'b0, 1));

    // Random clean, single-error and double-error words.
    for (int i = 0; i < 8; i++) begin
      data = 63'({$urandom(), $urandom()});
      par  = calc_parity(data);
      drive({par, data}, mk(data, 12'd0, 1'b0, 1'b0, 1'b0, 0));

      a = int'($urandom_range(0, 62));
      drive({par, data ^ (63'd1 << a)}, mk(data, 12'd0, 1'b1, 1'b1, 1'b0, 1));

      b = int'($urandom_range(0, 62));
      while (b == a) b = int'($urandom_range(0, 62));
      drive({par, data ^ (63'd1 << a) ^ (63'd1 << b)}, mk(data, 12'd0, 1'b1, 1'b0, 1'b1, 1));

      j = int'($urandom_range(0, 11));
      drive({par ^ (12'd1 << j), data}, mk(data ^ (63'd1 << (j + 51)), 12'd0, 1'b1, 1'b1, 1'b0, 1));
    end

    // Mid-stream reset: result for data=5 appears, then reset clears it at once.
    drive({par_tab[4], 63'd5}, mk(63'd5, 12'd0, 1'b0, 1'b0, 1'b0, 0));
    @(posedge clk);
    #1;
    check_front();
    #1;
    rst_n = 1'b0;
    #1;
    check_zero(-2);
    @(negedge clk);
    IN = {12'h539, 63'b111};
    @(negedge clk);
    check_zero(-3);
    rst_n = 1'b1;
    IN    = {par_tab[6], 63'd7};
    exp_q.push_back(mk(63'd7, 12'd0, 1'b0, 1'b0, 1'b0, 0));

    // A few more back-to-back words after reset release.
    drive({12'h539, 63'b11}, mk(63'd1, {6'b110110, 6'b001010}, 1'b1, 1'b1, 1'b0, 0));
    drive({par_tab[8], 63'd9}, mk(63'd9, 12'd0, 1'b0, 1'b0, 1'b0, 0));
    drive({12'h539, 63'b1111}, mk(63'd0, 12'd0, 1'b1, 1'b0, 1'b0, 2));

    // Drain the last queued result.
    @(negedge clk);
    while (exp_q.size() > 0) check_front();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
